text_renderer: RTL



---
 rtl/text_pkg.sv | 16 +
 rtl/video_delay.sv | 25 ++
 rtl/text_renderer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/text_pkg.sv
// Shared constants and fetch-state encoding for the text-mode renderer.
package text_pkg;
  localparam int CHAR_W     = 8;
  localparam int CHAR_H     = 8;
  localparam int ROW_STRIDE = 64;
  localparam int PIPE_LAT   = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHAR,
    ST_ATTR,
    ST_FONT,
    ST_GLYPH,
    ST_WAIT
  } fetch_state_e;
endpackage

// File: rtl/video_delay.sv
// Fixed-depth shift register that keeps timing signals aligned with the pixel pipeline.
module video_delay
  import text_pkg::*;
#(
  parameter int DEPTH = PIPE_LAT,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] d_o
);
  logic [W-1:0] pipe_q [DEPTH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign d_o = pipe_q[DEPTH-1];
endmodule

// File: rtl/text_renderer.sv
// Text-mode renderer: fetches char/attr/glyph per 8-pixel cell and shifts out colour indices.
// Optional TEXT_BLINK_EN: attr[7] becomes a blink flag driven by a vsync frame counter.
module text_renderer
  import text_pkg::*;
#(
  parameter int         COLS   = 30,
  parameter int         ROWS   = 17,
  parameter logic [3:0] BORDER = 4'h0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        de_i,
  input  logic        hs_i,
  input  logic        vs_i,
  output logic [10:0] ram_adb,
  output logic        ram_ceb,
  input  logic [7:0]  ram_dout,
  output logic [10:0] font_ad,
  output logic        font_ce,
  input  logic [7:0]  font_dout,
  output logic [3:0]  pix,
  output logic        de_o,
  output logic        hs_o,
  output logic        vs_o,
  output logic [2:0]  dbg_state_o
);
  fetch_state_e state_q, state_d;

  logic [2:0]  phase, line;
  logic [6:0]  col, row;
  logic        in_area, active, load, load_text;
  logic [10:0] char_addr;
  logic [7:0]  char_q, attr_q, glyph_q, shift_q;
  logic [3:0]  fg_q, bg_q, pix_q, fg_c, bg_c;
  logic        in_text_q;
  logic [2:0]  tim_d;

  assign phase     = x[2:0];
  assign line      = y[2:0];
  assign col       = x[9:3];
  assign row       = y[9:3];
  assign in_area   = (x < 10'(COLS * CHAR_W)) && (y < 10'(ROWS * CHAR_H));
  assign active    = de_i && in_area;
  assign char_addr = 11'(int'(row) * ROW_STRIDE + int'(col) * 2);

  always_comb begin
    state_d = state_q;
    ram_adb = '0;
    ram_ceb = 1'b0;
    font_ad = '0;
    font_ce = 1'b0;
    if (!active) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (phase == 3'd0) state_d = ST_CHAR;
        ST_CHAR: begin
          ram_adb = char_addr;
          ram_ceb = 1'b1;
          state_d = ST_ATTR;
        end
        ST_ATTR: begin
          ram_adb = char_addr + 11'd1;
          ram_ceb = 1'b1;
          state_d = ST_FONT;
        end
        ST_FONT: begin
          font_ad = {char_q, line};
          font_ce = 1'b1;
          state_d = ST_GLYPH;
        end
        ST_GLYPH: state_d = ST_WAIT;
        ST_WAIT:  if (phase == 3'd7) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Each read returns one cycle after its request, so data is captured in the following state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      char_q  <= '0;
      attr_q  <= '0;
      glyph_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_ATTR)  char_q  <= ram_dout;
      if (state_q == ST_FONT)  attr_q  <= ram_dout;
      if (state_q == ST_GLYPH) glyph_q <= font_dout;
    end
  end

`ifdef TEXT_BLINK_EN
  logic       vs_q;
  logic [5:0] frame_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vs_q    <= 1'b0;
      frame_q <= '0;
    end else begin
      vs_q <= vs_i;
      if (vs_i && !vs_q) frame_q <= frame_q + 6'd1;
    end
  end

  assign bg_c = {1'b0, attr_q[6:4]};
  assign fg_c = (attr_q[7] && frame_q[5]) ? bg_c : attr_q[3:0];
`else
  assign bg_c = attr_q[7:4];
  assign fg_c = attr_q[3:0];
`endif

  // Load at every phase 7; only a completed fetch marks the next slot as text.
  assign load      = (phase == 3'd7);
  assign load_text = (state_q == ST_WAIT) && active;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shift_q   <= '0;
      fg_q      <= '0;
      bg_q      <= '0;
      in_text_q <= 1'b0;
      pix_q     <= '0;
    end else begin
      if (load) begin
        shift_q   <= glyph_q;
        fg_q      <= fg_c;
        bg_q      <= bg_c;
        in_text_q <= load_text;
      end else begin
        shift_q <= {shift_q[6:0], 1'b0};
      end
      pix_q <= !in_text_q ? BORDER : (shift_q[7] ? fg_q : bg_q);
    end
  end

  video_delay #(.DEPTH(PIPE_LAT), .W(3)) u_delay (
    .clk    (clk),
    .resetn (resetn),
    .d_i    ({de_i, hs_i, vs_i}),
    .d_o    (tim_d)
  );

  assign {de_o, hs_o, vs_o} = tim_d;
  assign pix                = de_o ? pix_q : 4'h0;
  assign dbg_state_o        = state_q;
endmodule
